// File: rtl/div8_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width, counter sizing and the divide-by-zero quotient.
package div_pkg;

    // Default operand / quotient / remainder width.
    localparam int DIV_WIDTH = 8;

    // Width of the iteration counter, which must be able to count to WIDTH.
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

    // Quotient reported on divide-by-zero. The value is wide so that it can
    // be cast down to any supported WIDTH and still be all ones.
    localparam logic [63:0] DIV_DBZ_ALL_ONES = '1;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/div8_seq_if.sv
// Start/busy/done handshake bundle between the ALU control logic (master)
// and the sequential divider (slave).
interface div8_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div8_seq_subw.sv
// Parameterised ripple-carry subtractor: a - b computed as a + ~b + 1.
// borrow is the inverse of the final carry out.
module subw #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W-1:0] b_n;
    logic [W:0]   carry;

    assign b_n = ~b;

    // Ripple the carry through one full adder per bit, carry-in fixed at 1.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            diff[i]      = a[i] ^ b_n[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
        end
    end

    assign borrow = ~carry[W];

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider: one quotient bit per clock by shift and
// subtract, with a start/busy/done handshake and a divide-by-zero flag.
module div8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic        clk,
    input logic        rst_n,
    div8_seq_if.slave  bus
);

    localparam int               CNT_W     = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_diff;
    logic             sub_borrow;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_prem_msb;

    // Bring the next dividend bit into the partial remainder and trial-subtract.
    assign shifted = {prem_q[WIDTH-1:0], q_q[WIDTH-1]};

    subw #(
        .W (WIDTH + 1)
    ) u_subw (
        .a      (shifted),
        .b      ({1'b0, divisor_q}),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // Restore on borrow; the quotient bit is the inverse of the borrow.
    assign prem_next = sub_borrow ? shifted : sub_diff;
    assign q_next    = {q_q[WIDTH-2:0], ~sub_borrow};

    // A kept partial remainder is always below the divisor, so its top bit
    // is zero and never feeds the next shift.
    assign unused_prem_msb = prem_q[WIDTH];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    divisor_d = bus.divisor;
                    q_d       = bus.dividend;
                    prem_d    = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (bus.divisor == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = WIDTH'(DIV_DBZ_ALL_ONES);
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                prem_d = prem_next;
                q_d    = q_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = prem_next[WIDTH-1:0];
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
